ts_switch_sequencer: RTL and testbench

//  Sequences hitless channel switchovers on the 4:1 MPEG-2 TS output mux.

---
 rtl/ts_qos_pkg.sv | 19 +
 rtl/ts_timeout_counter.sv | 31 +++
 rtl/ts_switch_sequencer.sv | 172 +++++++++++++++++
 tb/tb_ts_switch_sequencer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/ts_qos_pkg.sv
// Shared definitions for the TS QoS output path: sequencer states,
// channel indices and the MPEG-2 TS packet length.
package ts_qos_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_EOP = 2'd1,
    ST_GAP      = 2'd2,
    ST_RUN      = 2'd3
  } sw_state_t;

  localparam logic [1:0] CH1 = 2'd0;
  localparam logic [1:0] CH2 = 2'd1;
  localparam logic [1:0] CH3 = 2'd2;
  localparam logic [1:0] CH4 = 2'd3;

  localparam int unsigned TS_PKT_LEN = 188;

endpackage

// File: rtl/ts_timeout_counter.sv
// Boundary-wait timer. Counts cycles while run=1. expire is asserted while
// the count equals limit; a limit of zero never expires. The count saturates
// so a disabled timer cannot wrap into a false match.
module ts_timeout_counter #(
  parameter int unsigned TMO_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             run,
  input  logic [TMO_W-1:0] limit,
  output logic             expire
);

  logic [TMO_W-1:0] cnt;

  // Cycle counter: clear has priority over counting.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (run && (cnt != '1)) begin
      cnt <= cnt + TMO_W'(1);
    end
  end

  // Expiry flag, only meaningful while the timer is running.
  always_comb begin
    expire = run && (limit != '0) && (cnt == limit);
  end

endmodule

// File: rtl/ts_switch_sequencer.sv
// Hitless channel switchover sequencer for the 4:1 TS output mux.
// A switch drains the old channel to EOP, then gates the mux until the
// target channel presents SOP, so only whole packets leave the mux.
module ts_switch_sequencer
  import ts_qos_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = 2,
  parameter int unsigned TMO_W  = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              req_valid,
  input  logic [CH_W-1:0]   req_channel,
  input  logic [TMO_W-1:0]  tmo_cycles,
  input  logic [NUM_CH-1:0] ch_valid,
  input  logic [NUM_CH-1:0] ch_sop,
  input  logic [NUM_CH-1:0] ch_eop,
  output logic [CH_W-1:0]   mux_sel,
  output logic              mux_en,
  output logic              busy,
  output logic              switch_done,
  output logic              switch_tmo,
  output logic [CNT_W-1:0]  switch_count
);

  sw_state_t       state, state_n;
  logic [CH_W-1:0] target, target_n, mux_sel_n;
  logic            done_n, tmo_n, cnt_inc;
  logic            tmr_clr, tmr_run, tmr_expire;
  logic            sel_sop, sel_eop;

  assign sel_sop = ch_valid[mux_sel] & ch_sop[mux_sel];
  assign sel_eop = ch_valid[mux_sel] & ch_eop[mux_sel];

  ts_timeout_counter #(
    .TMO_W(TMO_W)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .run    (tmr_run),
    .limit  (tmo_cycles),
    .expire (tmr_expire)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Select, target, status pulses and saturating switch statistic.
  always_ff @(posedge clk) begin
    if (rst) begin
      mux_sel      <= '0;
      target       <= '0;
      switch_done  <= 1'b0;
      switch_tmo   <= 1'b0;
      switch_count <= '0;
    end else begin
      mux_sel     <= mux_sel_n;
      target      <= target_n;
      switch_done <= done_n;
      switch_tmo  <= tmo_n;
      if (cnt_inc && (switch_count != '1)) begin
        switch_count <= switch_count + CNT_W'(1);
      end
    end
  end

  // Next-state and register-update decode.
  // Priority inside WAIT_EOP: cancel, then EOP, then timeout (EOP beats timeout).
  // Inside GAP: SOP beats both a retarget request and a timeout, because the
  // SOP byte already passed combinationally; a request to another channel in
  // that same cycle starts a fresh drain from the newly selected channel.
  always_comb begin
    state_n   = state;
    mux_sel_n = mux_sel;
    target_n  = target;
    done_n    = 1'b0;
    tmo_n     = 1'b0;
    cnt_inc   = 1'b0;
    tmr_clr   = 1'b0;
    tmr_run   = 1'b0;
    if (!enable) begin
      state_n  = ST_IDLE;
      target_n = mux_sel;
      tmr_clr  = 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: begin
          state_n = ST_GAP;
          tmr_clr = 1'b1;
          if (req_valid) begin
            target_n  = req_channel;
            mux_sel_n = req_channel;
          end else begin
            target_n = mux_sel;
          end
        end
        ST_RUN: begin
          tmr_clr = 1'b1;
          if (req_valid && (req_channel != mux_sel)) begin
            state_n  = ST_WAIT_EOP;
            target_n = req_channel;
          end
        end
        ST_WAIT_EOP: begin
          tmr_run = 1'b1;
          if (req_valid) begin
            target_n = req_channel;
          end
          if (req_valid && (req_channel == mux_sel)) begin
            state_n = ST_RUN;
            tmr_clr = 1'b1;
          end else if (sel_eop || tmr_expire) begin
            state_n   = ST_GAP;
            mux_sel_n = req_valid ? req_channel : target;
            tmr_clr   = 1'b1;
            tmo_n     = !sel_eop;
          end
        end
        ST_GAP: begin
          tmr_run = 1'b1;
          if (sel_sop) begin
            state_n = ST_RUN;
            done_n  = 1'b1;
            cnt_inc = 1'b1;
            tmr_clr = 1'b1;
            if (req_valid && (req_channel != mux_sel)) begin
              state_n  = ST_WAIT_EOP;
              target_n = req_channel;
            end
          end else if (req_valid) begin
            target_n  = req_channel;
            mux_sel_n = req_channel;
            tmr_clr   = 1'b1;
          end else if (tmr_expire) begin
            tmo_n   = 1'b1;
            tmr_clr = 1'b1;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Mux gate and busy flag; in GAP the gate opens only for the SOP byte.
  always_comb begin
    mux_en = 1'b0;
    busy   = 1'b0;
    unique case (state)
      ST_RUN:      mux_en = 1'b1;
      ST_WAIT_EOP: begin
        mux_en = 1'b1;
        busy   = 1'b1;
      end
      ST_GAP: begin
        mux_en = sel_sop;
        busy   = 1'b1;
      end
      default: mux_en = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_ts_switch_sequencer.sv
// Directed bench for ts_switch_sequencer: a per-cycle vector table covering
// reset, switching, gating, cancel, retarget and abort, followed by a
// hand-written timeout sequence.
module tb_ts_switch_sequencer;
  import ts_qos_pkg::*;

  logic        clk = 1'b0;
  logic        rst, enable, req_valid;
  logic [1:0]  req_channel;
  logic [15:0] tmo_cycles;
  logic [3:0]  ch_valid, ch_sop, ch_eop;
  logic [1:0]  mux_sel;
  logic        mux_en, busy, switch_done, switch_tmo;
  logic [15:0] switch_count;

  int n_tests = 0;
  int n_fail  = 0;

  ts_switch_sequencer #(
    .NUM_CH(4), .CH_W(2), .TMO_W(16), .CNT_W(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .req_valid    (req_valid),
    .req_channel  (req_channel),
    .tmo_cycles   (tmo_cycles),
    .ch_valid     (ch_valid),
    .ch_sop       (ch_sop),
    .ch_eop       (ch_eop),
    .mux_sel      (mux_sel),
    .mux_en       (mux_en),
    .busy         (busy),
    .switch_done  (switch_done),
    .switch_tmo   (switch_tmo),
    .switch_count (switch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, en, rv;
    logic [1:0]  rc;
    logic [3:0]  v, s, e;
    logic [1:0]  sel;
    logic        men, bsy, dn, tmo;
    logic [15:0] cnt;
  } vec_t;

  localparam int unsigned NV = 38;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic r, input logic en, input logic rv,
                              input logic [1:0] rc, input logic [3:0] v,
                              input logic [3:0] s, input logic [3:0] e,
                              input logic [1:0] sel, input logic men,
                              input logic bsy, input logic dn, input logic tmo,
                              input logic [15:0] cnt);
    vec_t t;
    t.rst = r; t.en = en; t.rv = rv; t.rc = rc; t.v = v; t.s = s; t.e = e;
    t.sel = sel; t.men = men; t.bsy = bsy; t.dn = dn; t.tmo = tmo; t.cnt = cnt;
    return t;
  endfunction

  // Apply one cycle of inputs at the falling edge and let outputs settle.
  task automatic drive(input logic r, input logic en, input logic rv,
                       input logic [1:0] rc, input logic [3:0] v,
                       input logic [3:0] s, input logic [3:0] e);
    @(negedge clk);
    rst = r; enable = en; req_valid = rv; req_channel = rc;
    ch_valid = v; ch_sop = s; ch_eop = e;
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  int first_tmo, second_tmo, n_tmo;

  initial begin
    rst = 1'b1; enable = 1'b0; req_valid = 1'b0; req_channel = '0;
    tmo_cycles = '0; ch_valid = '0; ch_sop = '0; ch_eop = '0;

    //               rst en rv rc  v     s     e     sel men bsy dn tmo cnt
    tbl[0]  = mk(1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 1, 1, 2, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(0, 1, 0, 0, 4'h4, 4'h0, 4'h0, 2, 0, 1, 0, 0, 0);
    tbl[6]  = mk(0, 1, 0, 0, 4'h4, 4'h4, 4'h0, 2, 1, 1, 0, 0, 0);
    tbl[7]  = mk(0, 1, 0, 0, 4'h4, 4'h0, 4'h0, 2, 1, 0, 1, 0, 1);
    tbl[8]  = mk(0, 1, 1, 0, 4'h5, 4'h1, 4'h0, 2, 1, 0, 0, 0, 1);
    tbl[9]  = mk(0, 1, 0, 0, 4'h5, 4'h0, 4'h0, 2, 1, 1, 0, 0, 1);
    tbl[10] = mk(0, 1, 0, 0, 4'h5, 4'h0, 4'h4, 2, 1, 1, 0, 0, 1);
    tbl[11] = mk(0, 1, 0, 0, 4'h1, 4'h0, 4'h0, 0, 0, 1, 0, 0, 1);
    tbl[12] = mk(0, 1, 0, 0, 4'h5, 4'h4, 4'h0, 0, 0, 1, 0, 0, 1);
    tbl[13] = mk(0, 1, 0, 0, 4'h1, 4'h1, 4'h0, 0, 1, 1, 0, 0, 1);
    tbl[14] = mk(0, 1, 0, 0, 4'h1, 4'h0, 4'h0, 0, 1, 0, 1, 0, 2);
    tbl[15] = mk(0, 1, 1, 0, 4'h0, 4'h0, 4'h0, 0, 1, 0, 0, 0, 2);
    tbl[16] = mk(0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 0, 1, 0, 0, 0, 2);
    tbl[17] = mk(0, 1, 1, 1, 4'h1, 4'h0, 4'h1, 0, 1, 0, 0, 0, 2);
    tbl[18] = mk(0, 1, 0, 0, 4'h1, 4'h0, 4'h1, 0, 1, 1, 0, 0, 2);
    tbl[19] = mk(0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 1, 0, 1, 0, 0, 2);
    tbl[20] = mk(0, 1, 0, 0, 4'h2, 4'h2, 4'h0, 1, 1, 1, 0, 0, 2);
    tbl[21] = mk(0, 1, 1, 3, 4'h0, 4'h0, 4'h0, 1, 1, 0, 1, 0, 3);
    tbl[22] = mk(0, 1, 1, 1, 4'h0, 4'h0, 4'h0, 1, 1, 1, 0, 0, 3);
    tbl[23] = mk(0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 1, 1, 0, 0, 0, 3);
    tbl[24] = mk(0, 1, 1, 2, 4'h0, 4'h0, 4'h0, 1, 1, 0, 0, 0, 3);
    tbl[25] = mk(0, 1, 1, 3, 4'h2, 4'h0, 4'h2, 1, 1, 1, 0, 0, 3);
    tbl[26] = mk(0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 3, 0, 1, 0, 0, 3);
    tbl[27] = mk(0, 1, 1, 1, 4'h0, 4'h0, 4'h0, 3, 0, 1, 0, 0, 3);
    tbl[28] = mk(0, 1, 0, 0, 4'h8, 4'h8, 4'h0, 1, 0, 1, 0, 0, 3);
    tbl[29] = mk(0, 1, 0, 0, 4'hA, 4'hA, 4'h0, 1, 1, 1, 0, 0, 3);
    tbl[30] = mk(0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 1, 1, 0, 1, 0, 4);
    tbl[31] = mk(0, 1, 1, 0, 4'h0, 4'h0, 4'h0, 1, 1, 0, 0, 0, 4);
    tbl[32] = mk(0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 1, 1, 1, 0, 0, 4);
    tbl[33] = mk(0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 1, 0, 0, 0, 0, 4);
    tbl[34] = mk(0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 1, 0, 0, 0, 0, 4);
    tbl[35] = mk(0, 1, 1, 2, 4'h0, 4'h0, 4'h0, 1, 0, 1, 0, 0, 4);
    tbl[36] = mk(1, 1, 0, 0, 4'h4, 4'h4, 4'h0, 2, 1, 1, 0, 0, 4);
    tbl[37] = mk(0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < int'(NV); i++) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].rv, tbl[i].rc, tbl[i].v, tbl[i].s, tbl[i].e);
      check($sformatf("vec%0d {sel,en,busy,done,tmo,cnt}", i),
            {9'd0, mux_sel, mux_en, busy, switch_done, switch_tmo, switch_count},
            {9'd0, tbl[i].sel, tbl[i].men, tbl[i].bsy, tbl[i].dn, tbl[i].tmo, tbl[i].cnt});
    end

    // Timeout sequence: settle on channel 1, then request channel 3 with
    // tmo_cycles=20 while channel 1 never ends its packet.
    drive(0, 1, 1, 2'd1, 4'h0, 4'h0, 4'h0);
    drive(0, 1, 0, 2'd0, 4'h2, 4'h2, 4'h0);
    tmo_cycles = 16'd20;
    drive(0, 1, 1, 2'd3, 4'h0, 4'h0, 4'h0);
    check("tmo_setup_run_ch1", {30'd0, mux_sel}, 32'd1);
    first_tmo = -1; second_tmo = -1; n_tmo = 0;
    for (int j = 0; j < 64; j++) begin
      if (j == 62) drive(0, 1, 0, 2'd0, 4'h8, 4'h8, 4'h0);
      else         drive(0, 1, 0, 2'd0, 4'h2, 4'h0, 4'h0);
      if (switch_tmo) begin
        n_tmo++;
        if (first_tmo < 0) first_tmo = j;
        else if (second_tmo < 0) second_tmo = j;
      end
      if (j == 20) check("tmo_still_draining", {30'd0, busy, mux_en}, 32'd3);
      if (j == 21) check("tmo_forced_gap_sel3", {29'd0, mux_sel, mux_en}, {29'd0, 2'd3, 1'b0});
      if (j == 62) check("tmo_sop_passes", {31'd0, mux_en}, 32'd1);
      if (j == 63) check("tmo_sop_wins_done", {15'd0, switch_done, switch_count}, {15'd0, 1'b1, 16'd2});
    end
    check("tmo_first_pulse_cycle", first_tmo, 21);
    check("tmo_second_pulse_cycle", second_tmo, 42);
    check("tmo_pulse_count", n_tmo, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
